// File: rtl/imem_arb_pkg.sv
// Shared widths, state and owner encodings for the instruction-memory port arbiter.
package imem_arb_pkg;

    localparam int IMEM_ADDR_W = 12;
    localparam int IMEM_DATA_W = 19;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_t;

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational grant selection between fetch and loader.
// With IMEM_ARB_RR_EN defined, RUN-state conflicts alternate using the last-grant pointer.
module imem_arb_pick
    import imem_arb_pkg::*;
(
    input  arb_state_t state,
    input  logic       f_req,
    input  logic       l_req,
`ifdef IMEM_ARB_RR_EN
    input  owner_t     rr_last,
    output logic       conflict,
`endif
    output logic       f_win,
    output logic       l_win
);

    always_comb begin
        f_win = 1'b0;
        l_win = 1'b0;
`ifdef IMEM_ARB_RR_EN
        conflict = 1'b0;
`endif
        if (state == BOOT) begin
            l_win = l_req;
        end else if (f_req && l_req) begin
`ifdef IMEM_ARB_RR_EN
            conflict = 1'b1;
            // Whoever won the last conflict yields this one.
            if (rr_last == OWN_FETCH) begin
                l_win = 1'b1;
            end else begin
                f_win = 1'b1;
            end
`else
            f_win = 1'b1;
`endif
        end else begin
            f_win = f_req;
            l_win = l_req;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch and the program loader.
// Optional IMEM_ARB_RR_EN: round-robin instead of fixed fetch priority on RUN conflicts.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_done,
    output logic              cpu_ready,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W:0]   load_cnt,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [ADDR_W:0] LOAD_CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LOAD_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    arb_state_t      state_q, state_d;
    owner_t          owner_q, owner_d;
    logic [ADDR_W:0] load_cnt_q, load_cnt_d;
    logic            f_win, l_win;

`ifdef IMEM_ARB_RR_EN
    owner_t rr_last_q, rr_last_d;
    logic   conflict;
`endif

    imem_arb_pick u_pick (
        .state    (state_q),
        .f_req    (f_req),
        .l_req    (l_req),
`ifdef IMEM_ARB_RR_EN
        .rr_last  (rr_last_q),
        .conflict (conflict),
`endif
        .f_win    (f_win),
        .l_win    (l_win)
    );

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (f_win) begin
            m_en   = 1'b1;
            m_addr = f_addr;
        end else if (l_win) begin
            m_en    = 1'b1;
            m_we    = l_we;
            m_addr  = l_addr;
            m_wdata = l_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = OWN_NONE;
        load_cnt_d = load_cnt_q;
        if (state_q == BOOT && boot_done) begin
            state_d = RUN;
        end
        if (f_win) begin
            owner_d = OWN_FETCH;
        end else if (l_win && !l_we) begin
            owner_d = OWN_LOADER;
        end
        // Only image writes during boot are counted; the count freezes in RUN.
        if (state_q == BOOT && l_win && l_we && load_cnt_q != LOAD_CNT_MAX) begin
            load_cnt_d = load_cnt_q + LOAD_CNT_ONE;
        end
    end

`ifdef IMEM_ARB_RR_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (conflict) begin
            rr_last_d = f_win ? OWN_FETCH : OWN_LOADER;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            owner_q    <= OWN_NONE;
            load_cnt_q <= '0;
`ifdef IMEM_ARB_RR_EN
            rr_last_q  <= OWN_LOADER;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            load_cnt_q <= load_cnt_d;
`ifdef IMEM_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

    assign f_gnt     = f_win;
    assign l_gnt     = l_win;
    assign cpu_ready = (state_q == RUN);
    assign f_rvalid  = (owner_q == OWN_FETCH);
    assign l_rvalid  = (owner_q == OWN_LOADER);
    assign f_rdata   = m_rdata;
    assign l_rdata   = m_rdata;
    assign load_cnt  = load_cnt_q;

endmodule
